// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - per-destination packet FIFO of the 1x3 router
// Optional fill_level occupancy port is enabled by defining ROUTER_FIFO_OCC_EN.
module router_pkt_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [7:0]        data_in,
  input  logic              read_enb,
  output logic              full,
  output logic              empty,
  output logic [7:0]        data_out,
  output logic              data_valid,
`ifdef ROUTER_FIFO_OCC_EN
  output logic [ADDR_W:0]   fill_level,
`endif
  output logic              pkt_last
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [6:0]        pkt_cnt;
  logic              wr_acc;
  logic              rd_acc;
  logic [8:0]        rd_word;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem[rd_ptr];

`ifdef ROUTER_FIFO_OCC_EN
  assign fill_level = count;
`endif

  // Storage carries no reset; a soft_reset cycle discards the write.
  always_ff @(posedge clock) begin
    if (wr_acc && !soft_reset)
      mem[wr_ptr] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // pkt_cnt counts the bytes still owed to the current packet, parity included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      pkt_last   <= 1'b0;
      pkt_cnt    <= '0;
    end else if (soft_reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      pkt_last   <= 1'b0;
      pkt_cnt    <= '0;
    end else if (rd_acc) begin
      data_out   <= rd_word[7:0];
      data_valid <= 1'b1;
      if (rd_word[8]) begin
        pkt_cnt  <= {1'b0, rd_word[7:2]} + 7'd1;
        pkt_last <= 1'b0;
      end else if (pkt_cnt != '0) begin
        pkt_cnt  <= pkt_cnt - 7'd1;
        pkt_last <= (pkt_cnt == 7'd1);
      end else begin
        pkt_last <= 1'b0;
      end
    end else begin
      data_valid <= 1'b0;
      pkt_last   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - directed self-checking bench for router_pkt_fifo
module tb_router_pkt_fifo;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic       full;
  logic       empty;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_last;
`ifdef ROUTER_FIFO_OCC_EN
  logic [4:0] fill_level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  router_pkt_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out),
    .data_valid (data_valid),
`ifdef ROUTER_FIFO_OCC_EN
    .fill_level (fill_level),
`endif
    .pkt_last   (pkt_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic lfd, input logic [7:0] d);
    write_enb = 1'b1;
    lfd_state = lfd;
    data_in   = d;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  initial begin
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    data_in = '0; read_enb = 1'b0;
    #3;
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_pkt_last", pkt_last, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    #4 reset = 1'b0;
    tick();

    // 1: header + 3 payload + parity
    push(1'b1, 8'h0D); push(1'b0, 8'hA1); push(1'b0, 8'hA2);
    push(1'b0, 8'hA3); push(1'b0, 8'h5E);
    read_enb = 1'b1;
    begin
      logic [7:0] exp1 [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
      for (int i = 0; i < 5; i++) begin
        tick();
        check($sformatf("t1_data_%0d", i), data_out, exp1[i]);
        check($sformatf("t1_valid_%0d", i), data_valid, 1);
        check($sformatf("t1_last_%0d", i), pkt_last, (i == 4));
      end
    end
    read_enb = 1'b0;
    tick();
    check("t1_valid_idle", data_valid, 0);
    check("t1_last_idle", pkt_last, 0);
    check("t1_empty", empty, 1);

    // 2: fill, overflow, write-at-full with read, drain
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_notfull_%0d", i), full, 0);
      push(1'b0, 8'(i));
    end
    check("t2_full", full, 1);
    push(1'b0, 8'hFF);
    check("t2_full_after_drop", full, 1);
    write_enb = 1'b1; data_in = 8'hFF; read_enb = 1'b1;
    tick();
    write_enb = 1'b0;
    check("t2_rw_at_full_data", data_out, 8'h00);
    check("t2_rw_at_full_notfull", full, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("t2_data_%0d", i), data_out, i);
      check($sformatf("t2_last_%0d", i), pkt_last, 0);
    end
    check("t2_empty", empty, 1);
    tick();
    check("t2_no_extra", data_valid, 0);
    read_enb = 1'b0;

    // 3: simultaneous read/write with 8 entries
    for (int i = 0; i < 8; i++) push(1'b0, 8'h20 + 8'(i));
    write_enb = 1'b1; read_enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h28 + 8'(i);
      tick();
      check($sformatf("t3_data_%0d", i), data_out, 8'h20 + i);
      check($sformatf("t3_full_%0d", i), full, 0);
      check($sformatf("t3_empty_%0d", i), empty, 0);
`ifdef ROUTER_FIFO_OCC_EN
      check($sformatf("t3_fill_%0d", i), fill_level, 8);
`endif
    end
    write_enb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t3_drain_%0d", i), data_out, 8'h24 + i);
    end
    read_enb = 1'b0;
    tick();
    check("t3_empty_end", empty, 1);

    // 4: soft_reset with 5 entries beats same-cycle read/write
    for (int i = 0; i < 5; i++) push(1'b0, 8'h40 + 8'(i));
    read_enb = 1'b1;
    tick();
    check("t4_pre_valid", data_valid, 1);
    soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h99;
    tick();
    soft_reset = 1'b0; write_enb = 1'b0;
    check("t4_empty", empty, 1);
    check("t4_valid", data_valid, 0);
    check("t4_data_cleared", data_out, 0);
`ifdef ROUTER_FIFO_OCC_EN
    check("t4_fill", fill_level, 0);
`endif
    tick();
    check("t4_read_nothing", data_valid, 0);
    read_enb = 1'b0;

    // 5: zero-length packet, then a truncated packet followed by a complete one
    push(1'b1, 8'h02); push(1'b0, 8'h02);
    read_enb = 1'b1;
    tick();
    check("t5_hdr_data", data_out, 8'h02);
    check("t5_hdr_last", pkt_last, 0);
    tick();
    check("t5_par_data", data_out, 8'h02);
    check("t5_par_last", pkt_last, 1);
    read_enb = 1'b0;
    push(1'b1, 8'h0D); push(1'b0, 8'hA1); push(1'b1, 8'h02); push(1'b0, 8'h33);
    read_enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_trunc_last_%0d", i), pkt_last, (i == 3));
    end
    read_enb = 1'b0;

    // 6: async reset between a read and its following cycle
    push(1'b0, 8'h77); push(1'b0, 8'h78);
    read_enb = 1'b1;
    tick();
    check("t6_pre_data", data_out, 8'h77);
    check("t6_pre_valid", data_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_data", data_out, 0);
    check("t6_valid", data_valid, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    read_enb = 1'b0;
    #2 reset = 1'b0;
    tick();
    check("t6_empty_after", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
